// File: rtl/bitcoin_pkg.sv
// Shared types, frame length, FSM state encoding and the nBits expansion helper.
package bitcoin_pkg;

  typedef logic [7:0][31:0] digest_t;
  typedef logic [255:0]     target_t;

  localparam int FRAME_LEN = 38;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    SEND    = 2'd2
  } rpt_state_t;

  // Expand compact nBits into a full 256-bit target; a set sign bit means target 0.
  function automatic target_t nbits_expand(input logic [31:0] bits);
    target_t    man;
    logic [7:0] expo;
    int         sh;
    man  = {232'd0, bits[23:0]};
    expo = bits[31:24];
    if (bits[23]) begin
      return '0;
    end else if (expo <= 8'd3) begin
      sh = 8 * (3 - int'(expo));
      return man >> sh;
    end else if (expo <= 8'd32) begin
      sh = 8 * (int'(expo) - 3);
      return man << sh;
    end else begin
      return '1;
    end
  endfunction

endpackage

// File: rtl/bitcoin_share_reporter_frame_tx.sv
// Serializes one share frame (sync, nonce, digest, XOR checksum) over a valid/ready byte stream.
module bitcoin_frame_tx
  import bitcoin_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] nonce,
  input  digest_t     digest,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        done
);

  localparam int SR_W = 8 * (FRAME_LEN - 1);

  logic [SR_W-1:0] shreg;
  logic [7:0]      chk;
  logic [5:0]      idx;
  logic            hs;
  logic            last;

  assign hs      = tx_valid && tx_ready;
  assign last    = (idx == 6'(FRAME_LEN - 1));
  assign tx_data = last ? chk : shreg[SR_W-1 -: 8];
  assign done    = hs && last;

  // Shift one byte out per handshake; the checksum covers every byte except sync and itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg    <= '0;
      chk      <= '0;
      idx      <= '0;
      tx_valid <= 1'b0;
    end else if (load) begin
      shreg    <= {SYNC_BYTE, nonce, digest};
      chk      <= '0;
      idx      <= '0;
      tx_valid <= 1'b1;
    end else if (hs) begin
      if (last) begin
        idx      <= '0;
        tx_valid <= 1'b0;
      end else begin
        shreg <= {shreg[SR_W-9:0], 8'h00};
        idx   <= idx + 6'd1;
        if (idx != 6'd0) chk <= chk ^ shreg[SR_W-1 -: 8];
      end
    end
  end

endmodule

// File: rtl/bitcoin_share_reporter.sv
// Checks mining results against their expanded target and reports shares as byte frames.
//   state   | meaning
//   IDLE    | waiting for a candidate, in_ready high
//   COMPARE | comparing digest vs target one 32-bit word per cycle, MSW first
//   SEND    | frame being streamed by bitcoin_frame_tx
module bitcoin_share_reporter
  import bitcoin_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_nonce,
  input  digest_t          in_digest,
  input  logic [31:0]      in_bits,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic [CNT_W-1:0] shares_found,
  output logic             busy
);

  rpt_state_t  state, state_nx;
  logic [2:0]  k;
  logic [31:0] nonce_q;
  digest_t     digest_q;
  digest_t     target_words;
  target_t     target_q;
  logic        cap, load, k_dec, done;
  logic [31:0] d_w, t_w;

  assign target_words = target_q;
  assign d_w          = digest_q[k];
  assign t_w          = target_words[k];
  assign in_ready     = (state == IDLE);
  assign busy         = (state != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state decode: capture, word compare decision, frame completion.
  always_comb begin
    state_nx = state;
    cap      = 1'b0;
    load     = 1'b0;
    k_dec    = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          cap      = 1'b1;
          state_nx = COMPARE;
        end
      end
      COMPARE: begin
        if (d_w < t_w) begin
          load     = 1'b1;
          state_nx = SEND;
        end else if (d_w > t_w) begin
          state_nx = IDLE;
        end else if (k == 3'd0) begin
          load     = 1'b1;
          state_nx = SEND;
        end else begin
          k_dec = 1'b1;
        end
      end
      SEND: begin
        if (done) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Candidate capture and compare word index.
  always_ff @(posedge clk) begin
    if (rst) begin
      k        <= 3'd7;
      nonce_q  <= '0;
      digest_q <= '0;
      target_q <= '0;
    end else if (cap) begin
      k        <= 3'd7;
      nonce_q  <= in_nonce;
      digest_q <= in_digest;
      target_q <= nbits_expand(in_bits);
    end else if (k_dec) begin
      k <= k - 3'd1;
    end
  end

  // Count frames whose last byte has been accepted.
  always_ff @(posedge clk) begin
    if (rst)       shares_found <= '0;
    else if (done) shares_found <= shares_found + 1'b1;
  end

  bitcoin_frame_tx #(.SYNC_BYTE(SYNC_BYTE)) u_frame_tx (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .nonce    (nonce_q),
    .digest   (digest_q),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .done     (done)
  );

endmodule

// File: tb/tb_bitcoin_share_reporter.sv
// Directed bench for bitcoin_share_reporter: accept/reject paths, nBits edges, backpressure, reset mid-frame.
module tb_bitcoin_share_reporter;
  import bitcoin_pkg::*;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_nonce;
  digest_t     in_digest;
  logic [31:0] in_bits;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] shares_found;
  logic        busy;

  int vectors     = 0;
  int miscompares = 0;

  bitcoin_share_reporter #(.SYNC_BYTE(8'hA5), .CNT_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_nonce     (in_nonce),
    .in_digest    (in_digest),
    .in_bits      (in_bits),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .shares_found (shares_found),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a candidate at a negedge; returns the number of compare cycles until a decision shows.
  task automatic offer(input logic [31:0] n, input digest_t dg, input logic [31:0] b, output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("in_ready_before_offer", in_ready, 1);
    in_valid  = 1'b1;
    in_nonce  = n;
    in_digest = dg;
    in_bits   = b;
    @(negedge clk);
    in_valid  = 1'b0;
    in_nonce  = ~n;
    in_digest = ~dg;
    in_bits   = 32'h2200_0000;
    check("compare_entry{busy,in_ready,tx_valid}", {busy, in_ready, tx_valid}, 3'b100);
    lat = 1;
    @(negedge clk);
    while (!tx_valid && !in_ready && lat < 20) begin
      lat++;
      @(negedge clk);
    end
  endtask

  // Collect a frame, checking each byte, stall stability and the end-of-frame state.
  task automatic recv_frame(input logic [31:0] n, input digest_t dg, input bit rnd,
                            input int abort_at, input logic [31:0] exp_sh);
    logic [7:0]   eb [FRAME_LEN];
    logic [255:0] flat;
    logic [7:0]   x;
    logic [7:0]   pd;
    logic         pv, phs;
    int           got, stall, cyc;
    flat  = dg;
    eb[0] = 8'hA5;
    for (int i = 0; i < 4; i++)  eb[1+i] = n[31-8*i -: 8];
    for (int i = 0; i < 32; i++) eb[5+i] = flat[255-8*i -: 8];
    x = 8'h00;
    for (int i = 1; i < 37; i++) x ^= eb[i];
    eb[37] = x;
    got = 0; stall = 0; cyc = 0; pv = 1'b0; phs = 1'b0; pd = 8'h00;
    while (got < FRAME_LEN && cyc < 800) begin
      if (pv && !phs) check("stall_hold{valid,data}", {tx_valid, tx_data}, {1'b1, pd});
      else            check("valid_in_frame", tx_valid, 1);
      if (abort_at >= 0 && got == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        check("abort_tx_valid", tx_valid, 0);
        check("abort_shares", shares_found, 0);
        check("abort_idle{in_ready,busy}", {in_ready, busy}, 2'b10);
        rst = 1'b0;
        tx_ready = 1'b1;
        @(negedge clk);
        check("abort_after_release_tx_valid", tx_valid, 0);
        return;
      end
      if (rnd) begin
        if (got == 20 && stall < 10) begin
          tx_ready = 1'b0;
          stall++;
        end else begin
          tx_ready = 1'($urandom_range(0, 1));
        end
      end else begin
        tx_ready = 1'b1;
      end
      if (tx_valid && tx_ready) begin
        check($sformatf("frame_byte_%0d", got), tx_data, eb[got]);
        got++;
      end
      pv  = tx_valid;
      phs = tx_valid && tx_ready;
      pd  = tx_data;
      @(negedge clk);
      cyc++;
    end
    check("frame_byte_count", got, FRAME_LEN);
    if (rnd) check("stall_cycles_at_b20", stall, 10);
    check("post_frame{tx_valid,in_ready,busy}", {tx_valid, in_ready, busy}, 3'b010);
    check("post_frame_shares", shares_found, exp_sh);
    tx_ready = 1'b1;
  endtask

  digest_t real_dg, ones_dg, one_dg, two_dg, fresh_dg;
  int      lat;

  initial begin
    real_dg  = {32'h00000000, 32'h00000000, 32'he067a478, 32'h024addfe,
                32'hcdc93628, 32'h978aa52d, 32'h91fabd42, 32'h92982a50};
    ones_dg  = '1;
    one_dg   = 256'h1;
    two_dg   = 256'h2;
    fresh_dg = {32'h00001234, 32'h89abcdef, 32'h01234567, 32'hfedcba98,
                32'h55aa55aa, 32'h0f0f0f0f, 32'hc3c3c3c3, 32'h7e7e7e7e};

    rst = 1'b1; tx_ready = 1'b1; in_valid = 1'b0;
    in_nonce = '0; in_digest = '0; in_bits = '0;
    @(negedge clk);
    @(negedge clk);
    check("reset{in_ready,tx_valid,busy}", {in_ready, tx_valid, busy}, 3'b100);
    check("reset_shares", shares_found, 0);
    check("reset_tx_data", tx_data, 0);
    rst = 1'b0;
    @(negedge clk);
    check("after_reset{in_ready,tx_valid,busy}", {in_ready, tx_valid, busy}, 3'b100);

    // Real block: word7 equal, word6 0 < 1 -> accept on 2nd compare cycle.
    offer(32'h33087548, real_dg, 32'h19015f53, lat);
    check("real_latency", lat, 2);
    check("real_first_byte", tx_data, 8'hA5);
    recv_frame(32'h33087548, real_dg, 1'b0, -1, 32'd1);

    // All-ones digest misses at word 7.
    offer(32'h11111111, ones_dg, 32'h19015f53, lat);
    check("reject_latency", lat, 1);
    check("reject{tx_valid,in_ready}", {tx_valid, in_ready}, 2'b01);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reject_quiet_tx_valid", tx_valid, 0);
    end
    check("reject_shares", shares_found, 1);

    // exp=3 target=1, digest equal -> accept after 8 cycles.
    offer(32'h00000003, one_dg, 32'h03000001, lat);
    check("equal_latency", lat, 8);
    check("equal_tx_valid", tx_valid, 1);
    recv_frame(32'h00000003, one_dg, 1'b0, -1, 32'd2);

    // Same target, digest 2 -> reject at word 0.
    offer(32'h00000004, two_dg, 32'h03000001, lat);
    check("above_latency", lat, 8);
    check("above{tx_valid,in_ready}", {tx_valid, in_ready}, 2'b01);
    check("above_shares", shares_found, 2);

    // Sign bit set -> target 0, digest 1 rejected at word 0.
    offer(32'h00000005, one_dg, 32'h03800001, lat);
    check("negative_latency", lat, 8);
    check("negative{tx_valid,in_ready}", {tx_valid, in_ready}, 2'b01);
    check("negative_shares", shares_found, 2);

    // exp=33 -> all-ones target, all-ones digest equal -> accept.
    offer(32'hcafef00d, ones_dg, 32'h21000001, lat);
    check("huge_latency", lat, 8);
    check("huge_tx_valid", tx_valid, 1);
    recv_frame(32'hcafef00d, ones_dg, 1'b0, -1, 32'd3);

    // Backpressure on the real block.
    offer(32'h33087548, real_dg, 32'h19015f53, lat);
    check("bp_latency", lat, 2);
    recv_frame(32'h33087548, real_dg, 1'b1, -1, 32'd4);

    // Reset at b=15, then a fresh candidate must produce a whole frame.
    offer(32'h33087548, real_dg, 32'h19015f53, lat);
    check("abort_latency", lat, 2);
    recv_frame(32'h33087548, real_dg, 1'b0, 15, 32'd0);
    offer(32'hdeadbeef, fresh_dg, 32'h21000001, lat);
    check("fresh_latency", lat, 1);
    recv_frame(32'hdeadbeef, fresh_dg, 1'b0, -1, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bitcoin_share_reporter.md
Name: bitcoin_share_reporter

Overview:
- Sits downstream of the mining core and accepts candidate results: nonce, final double-SHA256 digest, and compact target bits.
- Expands the compact nBits into a 256-bit target and compares the digest against it, one word per cycle.
- Results that meet the target (digest <= target) are serialized as a byte frame toward the host link (UART or bridge) over a valid/ready byte stream.
- Results that miss the target are dropped silently.

Parameters:
SYNC_BYTE, 8'hA5, first byte of every frame.
CNT_W, 32, width of the share counter.

Ports:
clk  in  1  system clock.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  candidate present.
in_ready  out  1  block can accept a candidate.
in_nonce  in  32  nonce of candidate.
in_digest  in  8x32 packed [7:0][31:0]  final digest; word 7 is most significant, and leading zeros appear in word 7.
in_bits  in  32  compact target (nBits).
tx_data  out  8  frame byte.
tx_valid  out  1  tx_data valid.
tx_ready  in  1  sink accepts byte.
shares_found  out  CNT_W  count of fully transmitted frames.
busy  out  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: single clock domain (clk); rst is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1, tx_valid=0, tx_data=0, shares_found=0, busy=0.
- Reset mid-operation: any in-flight compare or frame is abandoned. tx_valid drops on the reset edge and no partial-frame resume occurs.
- States: IDLE -> COMPARE -> (SEND | IDLE).
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at edge T, register nonce, digest and target_q = expand(in_bits).
  - Go to COMPARE with word index k=7.
- Target expansion (exp=bits[31:24], man=bits[23:0]):
  - If man[23]=1: target=0 (negative target).
  - Else if exp<=3: target = man >> 8*(3-exp).
  - Else if exp<=32: target = man << 8*(exp-3), keeping only bits 255:0; shifted-out bits are discarded.
  - Else (exp>32): target = all ones.
- COMPARE: one word per cycle, word k of digest against word k of target.
  - digest[k] < target[k]: accept.
  - digest[k] > target[k]: reject.
  - Equal and k>0: k decrements.
  - Equal and k==0: accept (equality counts as a share).
  - A decision made in cycle T+n takes effect at T+n+1:
    - Reject: IDLE, in_ready=1.
    - Accept: SEND with tx_valid=1 and tx_data=SYNC_BYTE.
  - Latency: 1 to 8 compare cycles. in_ready=0 throughout.
- SEND: 38-byte frame, index b=0..37.
  - b0: SYNC_BYTE.
  - b1..b4: nonce, MSB first.
  - b5..b36: digest, from in_digest[7][31:24] down to in_digest[0][7:0].
  - b37: XOR of b1..b36.
  - tx_data and tx_valid are held stable until tx_valid&&tx_ready; b advances on each handshake, one byte per cycle at most.
  - tx_valid is never deasserted mid-frame except by rst.
  - When b37 is accepted: shares_found increments (wraps modulo 2^CNT_W), state returns to IDLE and in_ready=1 next cycle. tx_valid=0 in that cycle.
- in_valid is ignored while in_ready=0; the upstream core must hold its candidate.
- A new candidate can be captured the cycle after return to IDLE. There is no back-to-back overlap.

Decomposition:
- Shared package bitcoin_pkg holds:
  - typedef digest_t (logic [7:0][31:0]).
  - typedef target_t (logic [255:0]).
  - FRAME_LEN=38.
  - enum rpt_state_t {IDLE, COMPARE, SEND}.
  - function nbits_expand(bits) -> target_t, also usable by the testbench model.
- Sub-module: bitcoin_frame_tx. It holds the 38-byte shift/index register, the checksum accumulator and the valid/ready byte handshake, and is started by a one-cycle load pulse from the compare FSM.

Test Plan:
- Reset check: assert rst for 2 cycles with tx_ready=1 -> in_ready=1, tx_valid=0, shares_found=0, busy=0.
- Real block:
  - Stimulus: nonce=32'h33087548, bits=32'h19015f53, digest words[7..0] = 00000000, 00000000, e067a478, 024addfe, cdc93628, 978aa52d, 91fabd42, 92982a50. target word6=32'h00000001, word5=32'h5f530000.
  - Response: accept decided at word 6 (2nd compare cycle). Frame begins A5 33 08 75 48 00 00 00 00 00 00 00 00 e0 67 a4 78 …, b37 = XOR of b1..b36, shares_found=1.
- Reject:
  - Stimulus: digest all 32'hffffffff, bits=32'h19015f53.
  - Response: decided at word 7, in_ready=1 two cycles after capture, tx_valid never asserted, shares_found unchanged.
- Expansion edges:
  - bits=32'h03000001 with digest=256'h1: accepted (equal, all 8 compare cycles).
  - Same bits with digest=256'h2: rejected.
  - bits=32'h03800001 with digest=256'h1: rejected (target 0).
  - bits=32'h21000001 with any digest: accepted.
- Backpressure:
  - Stimulus: during the real-block frame, toggle tx_ready pseudo-randomly and hold it low for 10 cycles at b=20.
  - Response: tx_data stable while stalled, no byte skipped or duplicated, 38 bytes total.
- Reset mid-frame: assert rst at b=15 -> tx_valid=0 next edge, shares_found=0, then a fresh candidate produces a complete correct frame.
